// File: rtl/alu_pkg.sv
// Shared opcode map, per-opcode ALU latency and issuer FSM encoding for the ALU command path.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_LLS = 4'b0111;
   localparam logic [3:0] OP_LRS = 4'b1000;
   localparam logic [3:0] OP_INC = 4'b1001;
   localparam logic [3:0] OP_DEC = 4'b1010;
   localparam logic [3:0] OP_NOP = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } issue_state_e;

   // MUL/DIV pass through an intermediate register inside the ALU.
   function automatic logic [1:0] alu_latency(input logic [3:0] op);
      return ((op == OP_MUL) || (op == OP_DIV)) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command and response valid/ready bundle between the sequencer (master) and the issuer (slave).
interface alu_cmd_issuer_if #(
   parameter int OPW  = 16,
   parameter int RESW = 32
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [3:0]      cmd_opcode;
   logic [OPW-1:0]  cmd_a;
   logic [OPW-1:0]  cmd_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [RESW-1:0] rsp_result;
   logic [3:0]      rsp_opcode;

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_opcode
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_opcode
   );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_cmd_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop && !empty)
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued ALU commands one at a time, waits the opcode latency, and returns the captured result.
//  state | meaning
//  IDLE  | nothing in flight; pops the FIFO head as soon as one is queued
//  WAIT  | command driven onto the ALU; latency down-counter running, capture at zero
//  RESP  | rsp_* held until taken; on the taking edge may pop the next command directly
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int OPW   = 16,
   parameter int RESW  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   alu_cmd_issuer_if.slave io,
   output logic [OPW-1:0]  alu_operand_a,
   output logic [OPW-1:0]  alu_operand_b,
   output logic [3:0]      alu_opcode,
   input  logic [RESW-1:0] alu_result,
   output logic            busy
);
   localparam int W = 4 + 2*OPW;

   issue_state_e    state_q, state_d;
   logic [1:0]      cnt_q;
   logic            pop, capture, rsp_take;
   logic            fifo_full, fifo_empty;
   logic [W-1:0]    fifo_rdata;
   logic [3:0]      head_op;
   logic [OPW-1:0]  head_a, head_b;
   logic            rsp_valid_q;
   logic [RESW-1:0] rsp_result_q;
   logic [3:0]      rsp_opcode_q;

   alu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (io.cmd_valid),
      .pop   (pop),
      .wdata ({io.cmd_opcode, io.cmd_a, io.cmd_b}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {head_op, head_a, head_b} = fifo_rdata;

   assign io.cmd_ready  = !fifo_full;
   assign io.rsp_valid  = rsp_valid_q;
   assign io.rsp_result = rsp_result_q;
   assign io.rsp_opcode = rsp_opcode_q;
   assign busy          = (state_q != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      capture  = 1'b0;
      rsp_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (io.rsp_ready) begin
               rsp_take = 1'b1;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ALU inputs are left holding the last command so multi-cycle ops see stable operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_operand_a <= '0;
         alu_operand_b <= '0;
         alu_opcode    <= OP_NOP;
         cnt_q         <= 2'd0;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_opcode_q  <= 4'd0;
      end else begin
         if (pop) begin
            alu_operand_a <= head_a;
            alu_operand_b <= head_b;
            alu_opcode    <= head_op;
            cnt_q         <= alu_latency(head_op);
         end else if ((state_q == ST_WAIT) && (cnt_q != 2'd0)) begin
            cnt_q <= cnt_q - 2'd1;
         end

         if (capture) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_opcode_q <= alu_opcode;
         end else if (rsp_take) begin
            rsp_valid_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and randomized checks of alu_cmd_issuer paired with a behavioural two-stage-MUL/DIV ALU.
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   localparam int OPW   = 16;
   localparam int RESW  = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] res;
   } exp_t;

   logic            clk;
   logic            reset;
   logic [OPW-1:0]  alu_operand_a, alu_operand_b;
   logic [3:0]      alu_opcode;
   logic [RESW-1:0] alu_result;
   logic [RESW-1:0] md_q;
   logic            busy;

   int   n_checks = 0;
   int   n_err    = 0;
   int   n_acc    = 0;
   int   n_rsp    = 0;
   exp_t exp_q[$];

   logic [3:0]  t3_op [6] = '{OP_AND, OP_OR, OP_XOR, OP_LLS, OP_LRS, OP_ADD};
   logic [15:0] t3_a  [6] = '{16'd15, 16'd120, 16'd134, 16'd134, 16'd134, 16'd1};
   logic [15:0] t3_b  [6] = '{16'd10, 16'd224, 16'd8, 16'd8, 16'd8, 16'd2};

   alu_cmd_issuer_if #(.OPW(OPW), .RESW(RESW)) io ();

   alu_cmd_issuer #(.OPW(OPW), .RESW(RESW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .io            (io),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_opcode    (alu_opcode),
      .alu_result    (alu_result),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] x, y;
      x = {16'h0, a};
      y = {16'h0, b};
      case (op)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_MUL:  return x * y;
         OP_DIV:  return (y == 32'd0) ? 32'd0 : x / y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         OP_LLS:  return x << y;
         OP_LRS:  return x >> y;
         OP_INC:  return x + 32'd1;
         OP_DEC:  return x - 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   // ALU stand-in: registered result, MUL/DIV through one extra register stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_q       <= '0;
         alu_result <= '0;
      end else begin
         md_q       <= ref_result(alu_opcode, alu_operand_a, alu_operand_b);
         alu_result <= ((alu_opcode == OP_MUL) || (alu_opcode == OP_DIV)) ? md_q
                       : ref_result(alu_opcode, alu_operand_a, alu_operand_b);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard handshakes seen before the coming edge, then advance to the next negedge.
   task automatic tick();
      exp_t e;
      if (io.cmd_valid && io.cmd_ready) begin
         exp_q.push_back('{io.cmd_opcode, ref_result(io.cmd_opcode, io.cmd_a, io.cmd_b)});
         n_acc++;
      end
      if (io.rsp_valid && io.rsp_ready) begin
         n_rsp++;
         n_checks++;
         assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL rsp_unexpected: observed response %0h expected none", io.rsp_result);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_result", io.rsp_result, e.res);
            chk("rsp_opcode", io.rsp_opcode, e.op);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      io.cmd_valid  = 1'b1;
      io.cmd_opcode = op;
      io.cmd_a      = a;
      io.cmd_b      = b;
      tick();
      io.cmd_valid  = 1'b0;
   endtask

   // Single command from idle with rsp_ready=1: pop on the next edge, response LAT+1 edges after it.
   task automatic run_single(input string tag, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [31:0] exp_res, input int lat);
      push1(op, a, b);
      chk({tag, "_busy_queued"}, busy, 1'b1);
      tick();
      chk({tag, "_alu_opcode"}, alu_opcode, op);
      chk({tag, "_alu_a"}, alu_operand_a, a);
      chk({tag, "_alu_b"}, alu_operand_b, b);
      chk({tag, "_valid_at_pop"}, io.rsp_valid, 1'b0);
      for (int k = 1; k <= lat; k++) begin
         tick();
         chk({tag, "_valid_early"}, io.rsp_valid, 1'b0);
      end
      tick();
      chk({tag, "_valid"}, io.rsp_valid, 1'b1);
      chk({tag, "_result"}, io.rsp_result, exp_res);
      chk({tag, "_opcode"}, io.rsp_opcode, op);
      tick();
      chk({tag, "_valid_cleared"}, io.rsp_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      int acc0, rsp0;
      reset         = 1'b1;
      io.cmd_valid  = 1'b0;
      io.cmd_opcode = 4'd0;
      io.cmd_a      = '0;
      io.cmd_b      = '0;
      io.rsp_ready  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", io.cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", io.rsp_valid, 1'b0);
      chk("rst_rsp_result", io.rsp_result, 32'd0);
      chk("rst_rsp_opcode", io.rsp_opcode, 4'd0);
      chk("rst_alu_opcode", alu_opcode, OP_NOP);
      chk("rst_alu_a", alu_operand_a, 16'd0);
      chk("rst_alu_b", alu_operand_b, 16'd0);
      reset = 1'b0;
      tick();

      // 1, 2, 6: single-command latency and forwarding
      run_single("add", OP_ADD, 16'd10, 16'd5, 32'd15, 1);
      run_single("mul", OP_MUL, 16'd10, 16'd3, 32'd30, 2);
      run_single("div", OP_DIV, 16'd25, 16'd5, 32'd5, 2);
      run_single("op_c", 4'b1100, 16'd7, 16'd9, 32'd0, 1);

      // 3: fill 1 in flight + DEPTH queued, sixth refused
      io.rsp_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         io.cmd_valid  = 1'b1;
         io.cmd_opcode = t3_op[i];
         io.cmd_a      = t3_a[i];
         io.cmd_b      = t3_b[i];
         chk("fill_cmd_ready", io.cmd_ready, (i < 5));
         tick();
      end
      io.cmd_valid = 1'b0;
      chk("fill_accepted", n_acc - acc0, 5);
      for (int k = 0; k < 4; k++) tick();
      chk("fill_hold_valid", io.rsp_valid, 1'b1);
      chk("fill_hold_result", io.rsp_result, 32'd10);
      chk("fill_hold_full", io.cmd_ready, 1'b0);
      io.rsp_ready = 1'b1;
      rsp0 = n_rsp;
      for (int k = 0; k < 60 && (n_rsp - rsp0) < 5; k++) tick();
      chk("fill_rsp_count", n_rsp - rsp0, 5);
      tick();
      chk("fill_idle", busy, 1'b0);

      // 4: back-to-back issue on the response edge
      io.rsp_ready = 1'b0;
      push1(OP_INC, 16'd45, 16'd0);
      push1(OP_DEC, 16'd27, 16'd0);
      tick();
      tick();
      chk("b2b_first_valid", io.rsp_valid, 1'b1);
      chk("b2b_first_result", io.rsp_result, 32'd46);
      io.rsp_ready = 1'b1;
      tick();
      chk("b2b_issue_opcode", alu_opcode, OP_DEC);
      chk("b2b_issue_a", alu_operand_a, 16'd27);
      chk("b2b_valid_low", io.rsp_valid, 1'b0);
      tick();
      tick();
      chk("b2b_second_valid", io.rsp_valid, 1'b1);
      chk("b2b_second_result", io.rsp_result, 32'd26);
      tick();
      chk("b2b_idle", busy, 1'b0);

      // 5: asynchronous reset while a MUL is waiting, with one more command queued
      push1(OP_MUL, 16'd7, 16'd6);
      push1(OP_ADD, 16'd3, 16'd3);
      #2 reset = 1'b1;
      #1;
      chk("arst_alu_opcode", alu_opcode, OP_NOP);
      chk("arst_alu_a", alu_operand_a, 16'd0);
      chk("arst_alu_b", alu_operand_b, 16'd0);
      chk("arst_rsp_valid", io.rsp_valid, 1'b0);
      chk("arst_rsp_result", io.rsp_result, 32'd0);
      chk("arst_rsp_opcode", io.rsp_opcode, 4'd0);
      chk("arst_cmd_ready", io.cmd_ready, 1'b1);
      chk("arst_busy", busy, 1'b0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("arst_still_empty", busy, 1'b0);
      run_single("post_rst_add", OP_ADD, 16'd1, 16'd1, 32'd2, 1);

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         io.cmd_valid  = ($urandom_range(0, 1) == 1);
         io.cmd_opcode = 4'($urandom_range(0, 15));
         io.cmd_a      = 16'($urandom);
         io.cmd_b      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         io.rsp_ready  = ($urandom_range(0, 3) != 0);
         tick();
         chk("rand_occupancy", (exp_q.size() <= DEPTH + 1), 1'b1);
      end
      io.cmd_valid = 1'b0;
      io.rsp_ready = 1'b1;
      for (int k = 0; k < 200 && (exp_q.size() != 0 || busy); k++) tick();
      chk("drain_outstanding", exp_q.size(), 0);
      chk("drain_busy", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
